// File: rtl/ifetch_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg
// Shared types and defaults for the instruction-fetch sequencer:
//   - fetch_state_e : sequencer FSM state (RUN / FAULT)
//   - fetch_entry_t : one prefetch queue entry {pc, instr}
//   - DEFAULT_DEPTH / DEFAULT_MEM_SIZE : default parameter values
// ---------------------------------------------------------------------------
package ifetch_pkg;

  localparam int DEFAULT_DEPTH    = 4;     // prefetch queue entries
  localparam int DEFAULT_MEM_SIZE = 1024;  // instruction ROM bytes

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage : ifetch_pkg

// File: rtl/ifetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// ifetch_sequencer_if
// Valid/ready handshake carrying fetched instructions to the consumer.
//   out_valid : head instruction available      (master -> slave)
//   out_instr : head instruction word           (master -> slave)
//   out_pc    : byte address of head instruction (master -> slave)
//   out_ready : consumer accepts head           (slave -> master)
// ---------------------------------------------------------------------------
interface ifetch_sequencer_if;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;

  modport master (output out_valid, output out_instr, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);

endinterface : ifetch_sequencer_if

// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
// DEPTH-entry FIFO of {pc, instr} prefetch entries with synchronous flush.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   i_push        : write i_push_data at the tail (caller never pushes when
//                   full unless it also pops)
//   i_push_data   : entry to write
//   i_pop         : retire the head entry (caller only pops when non-empty)
//   i_flush       : discard all entries; overrides push and pop
//   o_count       : occupancy 0..DEPTH
//   o_head        : oldest entry (meaningless while o_count == 0)
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_push,
  input  fetch_entry_t           i_push_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [$clog2(DEPTH):0] o_count,
  output fetch_entry_t           o_head
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  // NOTE: the entry array has no reset; an entry is only ever read after the
  // occupancy count says it was written, so its power-up contents are moot.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;  // idle, or push and pop cancel out
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule : ifetch_queue

// File: rtl/ifetch_sequencer.sv
// ---------------------------------------------------------------------------
// ifetch_sequencer
// Sequential instruction fetcher: walks a PC through a combinational ROM,
// buffers {pc, instr} in a small prefetch queue and hands the oldest entry
// to the consumer over a valid/ready handshake. A redirect flushes the queue
// and restarts fetch at the new target.
//
// Ports:
//   clk            : clock, all state on the rising edge
//   reset_n        : asynchronous active-low reset
//   imem_addr      : byte address to the ROM (= fetch_pc)
//   imem_instr     : ROM data for imem_addr, same cycle
//   redirect_valid : branch/jump redirect request
//   redirect_pc    : redirect target
//   out_if         : head-of-queue handshake (master side)
//   fault          : fetch stopped on a bad address
//
// Build option:
//   IFETCH_BOUNDS_CHECK_EN defined   : a misaligned or out-of-ROM fetch_pc
//                                      stops fetch (FAULT) until redirect.
//   IFETCH_BOUNDS_CHECK_EN undefined : fault tied low, fetch_pc wraps from
//                                      MEM_SIZE-4 back to 0.
// ---------------------------------------------------------------------------
module ifetch_sequencer
  import ifetch_pkg::*;
#(
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter int          MEM_SIZE = DEFAULT_MEM_SIZE,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  output logic [63:0]                imem_addr,
  input  logic [31:0]                imem_instr,
  input  logic                       redirect_valid,
  input  logic [63:0]                redirect_pc,
  ifetch_sequencer_if.master         out_if,
  output logic                       fault
);

  localparam int                 CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]   FULL_COUNT = CNT_W'(DEPTH);

  fetch_state_e     r_state;
  fetch_state_e     w_state_next;
  logic [63:0]      r_fetch_pc;
  logic [63:0]      w_fetch_pc_next;
  logic             w_push;
  logic             w_pop;
  logic             w_bad_pc;
  logic             w_has_room;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_head;
  fetch_entry_t     w_push_data;

`ifdef IFETCH_BOUNDS_CHECK_EN
  // Widened by one bit so a PC near 2^64 cannot wrap past the bound.
  assign w_bad_pc = (r_fetch_pc[1:0] != 2'b00) ||
                    (({1'b0, r_fetch_pc} + 65'd3) >= 65'(MEM_SIZE));
  assign fault    = (r_state == FAULT);
`else
  assign w_bad_pc = 1'b0;
  assign fault    = 1'b0;
`endif

  assign imem_addr   = r_fetch_pc;
  assign w_pop       = out_if.out_valid && out_if.out_ready;
  // A pop this cycle frees the slot the push needs, even when full.
  assign w_has_room  = (w_count != FULL_COUNT) || w_pop;
  assign w_push      = (r_state == RUN) && !redirect_valid && !w_bad_pc && w_has_room;
  assign w_push_data = '{pc: r_fetch_pc, instr: imem_instr};

  // Head data is forced to zero while empty so the consumer never sees stale
  // entries; while non-empty it only changes on a pop, flush or reset.
  assign out_if.out_valid = (w_count != '0);
  assign out_if.out_instr = out_if.out_valid ? w_head.instr : '0;
  assign out_if.out_pc    = out_if.out_valid ? w_head.pc    : '0;

  // NOTE: every always_comb output gets a default first so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      w_state_next = RUN;
    end else if ((r_state == RUN) && w_bad_pc) begin
      w_state_next = FAULT;
    end
  end

  always_comb begin
    w_fetch_pc_next = r_fetch_pc;
    if (redirect_valid) begin
      w_fetch_pc_next = redirect_pc;
    end else if (w_push) begin
`ifdef IFETCH_BOUNDS_CHECK_EN
      // Running off the ROM end is caught by the bound check next cycle.
      w_fetch_pc_next = r_fetch_pc + 64'd4;
`else
      w_fetch_pc_next = (r_fetch_pc == (64'(MEM_SIZE) - 64'd4)) ? '0
                                                                 : r_fetch_pc + 64'd4;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= RUN;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
    end
  end

  // A same-cycle pop on redirect needs no special handling: the flush empties
  // the queue, which retires the head along with everything behind it.
  ifetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_count     (w_count),
    .o_head      (w_head)
  );

endmodule : ifetch_sequencer

// File: tb/tb_ifetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ifetch_sequencer
// Scoreboard bench for ifetch_sequencer. The ROM returns word index as data
// (word i = i). Each phase loads the expected {pc, instr} stream into a
// queue; a monitor pops and compares on every accepted handshake.
// ---------------------------------------------------------------------------
module tb_ifetch_sequencer;
  import ifetch_pkg::*;

  localparam int          MEM_SIZE = 1024;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fault;

  ifetch_sequencer_if u_out_if ();

  always #5 clk = ~clk;

  // Combinational ROM: word i holds value i.
  assign imem_instr = imem_addr[33:2];

  ifetch_sequencer #(
    .DEPTH    (4),
    .MEM_SIZE (MEM_SIZE),
    .RESET_PC (RESET_PC)
  ) u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_if         (u_out_if),
    .fault          (fault)
  );

  fetch_entry_t exp_q[$];
  fetch_entry_t mon_e;
  int           checks = 0;
  int           errors = 0;
  int           pops   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Replace the scoreboard with n sequential fetches starting at start_pc.
  task automatic expect_stream(input logic [63:0] start_pc, input int n);
    logic [63:0] pc;
    fetch_entry_t e;
    pc = start_pc;
    exp_q.delete();
    pops = 0;
    for (int i = 0; i < n; i++) begin
      e.pc    = pc;
      e.instr = pc[33:2];
      exp_q.push_back(e);
      pc = (pc == 64'(MEM_SIZE - 4)) ? 64'h0 : pc + 64'd4;
    end
  endtask

  // Handshake sampled mid-cycle; the pop itself happens on the next rise.
  always @(negedge clk) begin
    if (reset_n && u_out_if.out_valid && u_out_if.out_ready) begin
      check("pop_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("out_pc", u_out_if.out_pc, mon_e.pc);
        check("out_instr", 64'(u_out_if.out_instr), 64'(mon_e.instr));
      end
      pops++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n          = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = 64'h0;
    u_out_if.out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_valid", 64'(u_out_if.out_valid), 64'd0);
    check("rst_pc", u_out_if.out_pc, 64'd0);
    check("rst_instr", 64'(u_out_if.out_instr), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_imem_addr", imem_addr, RESET_PC);

    // Streaming with consumer always ready: one instruction per cycle
    expect_stream(RESET_PC, 64);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("first_valid", 64'(u_out_if.out_valid), 64'd1);
    check("first_pc", u_out_if.out_pc, RESET_PC);
    repeat (7) @(posedge clk);
    #1;
    check("stream_pops", 64'(pops), 64'd7);

    // Back-pressure: queue fills, fetch stalls at 16, head held
    reset_n = 1'b0;
    u_out_if.out_ready = 1'b0;
    #1;
    check("rst2_valid", 64'(u_out_if.out_valid), 64'd0);
    expect_stream(RESET_PC, 64);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_pc", u_out_if.out_pc, 64'h0);
    end
    check("stall_fetch_pc", imem_addr, 64'd16);
    check("stall_valid", 64'(u_out_if.out_valid), 64'd1);
    check("stall_pops", 64'(pops), 64'd0);
    u_out_if.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("drain_pops", 64'(pops), 64'd5);

    // Redirect with a full queue: head consumed, rest dropped, one bubble
    redirect_valid = 1'b1;
    redirect_pc    = 64'h40;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    expect_stream(64'h40, 64);
    check("redir_bubble", 64'(u_out_if.out_valid), 64'd0);
    check("redir_fetch_pc", imem_addr, 64'h40);
    @(posedge clk); #1;
    check("redir_valid", 64'(u_out_if.out_valid), 64'd1);
    check("redir_pc", u_out_if.out_pc, 64'h40);
    check("redir_instr", 64'(u_out_if.out_instr), 64'h10);

`ifdef IFETCH_BOUNDS_CHECK_EN
    // Fetch runs off the ROM end: four good entries, then FAULT
    u_out_if.out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3F0;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    expect_stream(64'h3F0, 4);
    repeat (8) @(posedge clk);
    #1;
    check("oob_fault", 64'(fault), 64'd1);
    check("oob_fetch_pc", imem_addr, 64'h400);
    check("oob_head_pc", u_out_if.out_pc, 64'h3F0);
    u_out_if.out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("oob_drain_pops", 64'(pops), 64'd4);
    check("oob_empty", 64'(u_out_if.out_valid), 64'd0);
    check("oob_fault_held", 64'(fault), 64'd1);

    // Misaligned redirect target: nothing pushed, FAULT next cycle
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3FE;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    expect_stream(64'h3FE, 0);
    check("mis_fault_clear", 64'(fault), 64'd0);
    @(posedge clk); #1;
    check("mis_fault", 64'(fault), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("mis_no_push", 64'(u_out_if.out_valid), 64'd0);

    // Redirect to 0 clears the fault
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    expect_stream(64'h0, 64);
    check("clr_fault", 64'(fault), 64'd0);
    @(posedge clk); #1;
    check("clr_valid", 64'(u_out_if.out_valid), 64'd1);
    check("clr_pc", u_out_if.out_pc, 64'h0);
`else
    // Fetch wraps from MEM_SIZE-4 to 0 without faulting
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3F0;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    expect_stream(64'h3F0, 64);
    repeat (10) @(posedge clk);
    #1;
    check("wrap_pops", 64'(pops), 64'd9);
    check("wrap_fault", 64'(fault), 64'd0);
`endif

    // Reset mid-stream with a full queue
    u_out_if.out_ready = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    check("pre_rst_full", 64'(u_out_if.out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(u_out_if.out_valid), 64'd0);
    check("mid_rst_pc", u_out_if.out_pc, 64'd0);
    check("mid_rst_imem_addr", imem_addr, RESET_PC);
    check("mid_rst_fault", 64'(fault), 64'd0);
    expect_stream(RESET_PC, 64);
    #2;
    reset_n = 1'b1;
    u_out_if.out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", 64'(u_out_if.out_valid), 64'd1);
    check("post_rst_pc", u_out_if.out_pc, RESET_PC);
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_pops", 64'(pops), 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ifetch_sequencer

// File: doc/ifetch_sequencer.md
IFETCH_SEQUENCER -- requirements
Module: ifetch_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning prefetch queue entries (power of two, >=2).
REQ-002 SHALL have parameter MEM_SIZE, default 1024, meaning instruction ROM size in bytes (power of two).
REQ-003 SHALL have parameter RESET_PC, default 64'h0, meaning first fetch address after reset.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on posedge clk.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port imem_addr, output, 64, byte address driven to the combinational instruction ROM.
REQ-007 SHALL have port imem_instr, input, 32, ROM read data for imem_addr in the same cycle.
REQ-008 SHALL have port redirect_valid, input, 1, branch/jump redirect request.
REQ-009 SHALL have port redirect_pc, input, 64, redirect target.
REQ-010 SHALL have port out_valid, output, 1, head instruction available.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts head.
REQ-012 SHALL have port out_instr, output, 32, head instruction.
REQ-013 SHALL have port out_pc, output, 64, address of head instruction.
REQ-014 SHALL have port fault, output, 1, fetch stopped on bad address (bounds-check builds only).

Function
REQ-015 SHALL hold fetch_pc, a DEPTH-entry queue of {pc, instr}, occupancy count 0..DEPTH, and FSM state RUN or FAULT.
REQ-016 SHALL drive imem_addr = fetch_pc combinationally every cycle.
REQ-017 SHALL push {fetch_pc, imem_instr} and advance fetch_pc by 4 in RUN when no redirect and (count<DEPTH or a pop occurs that cycle).
REQ-018 SHALL assert out_valid iff count>0, presenting the oldest entry on out_instr/out_pc; pop when out_valid && out_ready.
REQ-019 SHALL keep count unchanged on simultaneous push and pop; full with no pop SHALL stall fetch_pc.
REQ-020 SHALL, on redirect_valid, complete any same-cycle pop, discard all other entries (count=0), suppress that cycle's push, load fetch_pc=redirect_pc, and enter RUN.
REQ-021 SHALL present the redirect target's instruction with out_valid=1 exactly two edges after the redirect edge (one empty cycle).
REQ-022 SHALL wrap queue read/write pointers modulo DEPTH.
REQ-023 SHALL hold out_instr/out_pc stable while out_valid && !out_ready.

Reset
REQ-024 SHALL on reset_n=0 immediately set fetch_pc=RESET_PC, count=0, pointers=0, state=RUN, out_valid=0, fault=0; out_instr/out_pc SHALL read 0 when empty.
REQ-025 SHALL discard any mid-operation queue contents on reset; first push occurs on the first edge after reset_n rises.

Configuration
REQ-026 SHALL with IFETCH_BOUNDS_CHECK_EN defined: in RUN, if fetch_pc[1:0]!=0 or fetch_pc+3>=MEM_SIZE, no push occurs, state->FAULT, fault=1 next cycle; queue drains normally; only redirect or reset leaves FAULT.
REQ-027 SHALL without IFETCH_BOUNDS_CHECK_EN: tie fault=0, never enter FAULT, and advance fetch_pc from MEM_SIZE-4 to 0 (wrap).

Structure
REQ-028 SHALL place state enum (RUN, FAULT), queue entry struct {pc[63:0], instr[31:0]}, and default DEPTH/MEM_SIZE constants in package ifetch_pkg.
REQ-029 SHALL implement the queue as sub-module ifetch_queue (push/pop/flush, count, head data); FSM and PC logic stay in ifetch_sequencer.

Verification
REQ-030 SHALL test reset then out_ready=1 with ROM word i = i -> out_pc 0,4,8,... and out_instr 0,1,2,... one per cycle, out_valid high from first edge.
REQ-031 SHALL test out_ready=0 for 10 cycles -> count=4, fetch_pc=16 held, head pc 0 stable; out_ready=1 -> pc 0,4,8,12,16 consecutive.
REQ-032 SHALL test redirect_pc=0x40 while queue holds 4 entries and out_ready=1 -> head consumed, others dropped, one empty cycle, then out_pc=0x40.
REQ-033 SHALL test (EN defined) redirect_pc=0x3FE or fetch reaching 0x400 -> no push of bad pc, fault=1, remaining entries drain; redirect_pc=0 clears fault.
REQ-034 SHALL test (EN undefined) fetch past 0x3FC -> next out_pc=0, fault stays 0.
REQ-035 SHALL test reset_n pulsed low mid-stream with full queue -> out_valid=0 immediately, next out_pc=RESET_PC.
